// File: rtl/filter_pkg.sv
// Shared constants for the sharpening filter front end: pixel width, line-buffer
// sizing defaults and the line-buffer FSM encoding.
package filter_pkg;

  localparam int unsigned PIX_WIDTH         = 8;
  localparam int unsigned DEFAULT_DEPTH     = 512;
  localparam int unsigned DEFAULT_LINE_BITS = 10;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFill   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

endpackage

// File: rtl/line_ram.sv
// Single-port line memory. The read is combinational, so in a write cycle
// rd_data_o still shows the value stored before the edge (read-before-write).
module line_ram
  import filter_pkg::*;
#(
  parameter int unsigned WIDTH     = PIX_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned LINE_BITS = DEFAULT_LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [LINE_BITS-1:0] addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] addr;

  assign addr = addr_i[AddrW-1:0];

  // The column counter never reaches DEPTH, so any extra address bits stay zero.
  if (LINE_BITS > AddrW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[LINE_BITS-1:AddrW];
  end

  assign rd_data_o = mem_q[addr];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr] <= wr_data_i;
    end
  end

endmodule

// File: rtl/multi_line_buffer.sv
// KROWS-row vertical window over a raster stream: a cascade of KROWS-1 line RAMs
// plus the frame FSM, column/row counters and the registered column output.
module multi_line_buffer
  import filter_pkg::*;
#(
  parameter int unsigned WIDTH     = PIX_WIDTH,
  parameter int unsigned KROWS     = 3,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned LINE_BITS = DEFAULT_LINE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LINE_BITS-1:0]   line_length,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   data_in_valid,
  input  logic                   frame_start,
  output logic [KROWS*WIDTH-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   data_out_eol,
  output logic                   busy
);

  localparam int unsigned RowW = $clog2(KROWS);
  localparam logic [RowW-1:0]      RowLast = RowW'(KROWS - 1);
  localparam logic [RowW-1:0]      RowFill = RowW'(KROWS - 2);
  localparam logic [LINE_BITS-1:0] DepthL  = LINE_BITS'(DEPTH);

  logic [1:0]             state_q, state_d;
  logic [LINE_BITS-1:0]   col_q, col_d;
  logic [RowW-1:0]        row_q, row_d;
  logic [LINE_BITS-1:0]   len_q, len_d;
  logic [KROWS*WIDTH-1:0] dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   eol_q, eol_d;

  logic                   accept, restart, last;
  logic [LINE_BITS-1:0]   len_clamp, eff_col, eff_len;
  logic [RowW-1:0]        eff_row;
  logic [1:0]             eff_state;
  logic [WIDTH-1:0]       ram_wr [KROWS-1];
  logic [WIDTH-1:0]       ram_rd [KROWS-1];

  always_comb begin
    accept    = data_in_valid && ((state_q != StIdle) || frame_start);
    restart   = accept && frame_start;
    len_clamp = ((line_length == '0) || (line_length > DepthL)) ? DepthL : line_length;

    // A frame-start pixel is processed as column 0 of a fresh frame in FILL.
    eff_col   = restart ? '0 : col_q;
    eff_row   = restart ? '0 : row_q;
    eff_len   = restart ? len_clamp : len_q;
    eff_state = restart ? StFill : state_q;
    last      = (eff_col == (eff_len - 1'b1));

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    len_d   = len_q;
    if (accept) begin
      len_d = eff_len;
      col_d = last ? '0 : eff_col + 1'b1;
      row_d = (last && (eff_row != RowLast)) ? eff_row + 1'b1 : eff_row;
      state_d = ((eff_state == StFill) && last && (eff_row == RowFill)) ? StStream : eff_state;
    end

    valid_d = accept && (eff_state == StStream);
    eol_d   = valid_d && last;

    ram_wr[0] = data_in;
    for (int j = 1; j < KROWS - 1; j++) begin
      ram_wr[j] = ram_rd[j-1];
    end

    dout_d = dout_q;
    if (accept) begin
      dout_d[WIDTH-1:0] = data_in;
      for (int k = 1; k < KROWS; k++) begin
        dout_d[k*WIDTH +: WIDTH] = ram_rd[k-1];
      end
    end
  end

  for (genvar j = 0; j < KROWS - 1; j++) begin : g_ram
    line_ram #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .LINE_BITS (LINE_BITS)
    ) u_line_ram (
      .clk_i     (clk),
      .we_i      (accept),
      .addr_i    (eff_col),
      .wr_data_i (ram_wr[j]),
      .rd_data_o (ram_rd[j])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      len_q   <= DepthL;
      dout_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = valid_q;
  assign data_out_eol   = eol_q;
  assign busy           = (state_q != StIdle);

endmodule
